// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - request/result bundle between a datapath and the serial adder sequencer
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract sequencer driving one external 1-bit full adder
// Operands are latched on start and fed LSB first; sum/cout/ovf are captured on the last bit.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus,
    output logic                fa_a,
    output logic                fa_b,
    output logic                fa_cin,
    input  logic                fa_s,
    input  logic                fa_cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
                    sa_d    = bus.a;
                    sb_d    = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = {fa_s, sr_q[WIDTH-1:1]};
                c_d   = fa_cout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // c_q is the carry into the MSB, fa_cout the carry out of it.
                    sum_d   = {fa_s, sr_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = c_q ^ fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fa_a   = (state_q == S_RUN) ? sa_q[0] : 1'b0;
    assign fa_b   = (state_q == S_RUN) ? sb_q[0] : 1'b0;
    assign fa_cin = (state_q == S_RUN) ? c_q     : 1'b0;

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl with a behavioural full adder
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic fa_a, fa_b, fa_cin, fa_s, fa_cout;

    int n_vec = 0;
    int n_err = 0;

    serial_adder_ctrl_if #(.WIDTH(W)) bus_if ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_s    (fa_s),
        .fa_cout (fa_cout)
    );

    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer arithmetic on the operands as numbers.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] s, output logic c, output logic o);
        int ua, ub, ia, ib, r_u, r_s;
        ua  = int'(a);
        ub  = int'(b);
        ia  = a[W-1] ? ua - (1 << W) : ua;
        ib  = b[W-1] ? ub - (1 << W) : ub;
        r_u = sub ? ua - ub : ua + ub;
        r_s = sub ? ia - ib : ia + ib;
        s   = W'(r_u);
        c   = sub ? (ua >= ub) : (r_u >= (1 << W));
        o   = (r_s > (1 << (W - 1)) - 1) || (r_s < -(1 << (W - 1)));
    endfunction

    // Carry into bit i of a + bx + cin, from the numeric value of the low bits.
    function automatic logic carry_in(input logic [W-1:0] a, input logic [W-1:0] bx, input logic cin, input int i);
        int lo_a, lo_b;
        lo_a = int'(a) % (1 << i);
        lo_b = int'(bx) % (1 << i);
        return ((lo_a + lo_b + int'(cin)) >> i) != 0;
    endfunction

    task automatic check_idle_fa(input string tag);
        expect_eq({tag, "_fa_a"},   32'(fa_a),   32'd0);
        expect_eq({tag, "_fa_b"},   32'(fa_b),   32'd0);
        expect_eq({tag, "_fa_cin"}, 32'(fa_cin), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input string tag);
        logic [W-1:0] bx, es;
        logic ec, eo;
        bx = sub ? ~b : b;
        model(a, b, sub, es, ec, eo);
        bus_if.start = 1'b1;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.sub   = sub;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.a     = W'($urandom);
        bus_if.b     = W'($urandom);
        bus_if.sub   = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            expect_eq({tag, "_busy"},   32'(bus_if.busy), 32'd1);
            expect_eq({tag, "_done0"},  32'(bus_if.done), 32'd0);
            expect_eq({tag, "_fa_a"},   32'(fa_a),   32'(a[i]));
            expect_eq({tag, "_fa_b"},   32'(fa_b),   32'(bx[i]));
            expect_eq({tag, "_fa_cin"}, 32'(fa_cin), 32'(carry_in(a, bx, sub, i)));
        end
        @(negedge clk);
        expect_eq({tag, "_done"}, 32'(bus_if.done), 32'd1);
        expect_eq({tag, "_busyd"}, 32'(bus_if.busy), 32'd1);
        expect_eq({tag, "_sum"},  32'(bus_if.sum),  32'(es));
        expect_eq({tag, "_cout"}, 32'(bus_if.cout), 32'(ec));
        expect_eq({tag, "_ovf"},  32'(bus_if.ovf),  32'(eo));
        check_idle_fa({tag, "_dn"});
        @(negedge clk);
        expect_eq({tag, "_done_end"}, 32'(bus_if.done), 32'd0);
        expect_eq({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
        expect_eq({tag, "_sum_hold"}, 32'(bus_if.sum),  32'(es));
        check_idle_fa({tag, "_id"});
    endtask

    initial begin
        int dones;
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.sub   = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_eq("rst_busy", 32'(bus_if.busy), 32'd0);
        expect_eq("rst_done", 32'(bus_if.done), 32'd0);
        expect_eq("rst_sum",  32'(bus_if.sum),  32'd0);
        expect_eq("rst_cout", 32'(bus_if.cout), 32'd0);
        expect_eq("rst_ovf",  32'(bus_if.ovf),  32'd0);
        check_idle_fa("rst");
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h35, 8'h4A, 1'b0, "add35_4a");
        run_op(8'hFF, 8'h01, 1'b0, "addff_01");
        run_op(8'h7F, 8'h01, 1'b0, "add7f_01");
        run_op(8'h05, 8'h07, 1'b1, "sub05_07");
        run_op(8'h80, 8'h01, 1'b1, "sub80_01");

        // start held high: one acceptance every W+2 cycles
        bus_if.start = 1'b1;
        bus_if.a     = 8'h10;
        bus_if.b     = 8'h20;
        bus_if.sub   = 1'b0;
        dones        = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            expect_eq("hold_busy", 32'(bus_if.busy), 32'((k % (W + 2)) != W + 1));
            expect_eq("hold_done", 32'(bus_if.done), 32'((k % (W + 2)) == W));
            if (bus_if.done) begin
                dones++;
                expect_eq("hold_sum", 32'(bus_if.sum), 32'h30);
            end
        end
        bus_if.start = 1'b0;
        expect_eq("hold_count", 32'(dones), 32'd3);
        @(negedge clk);

        // reset while bit 3 is being presented
        bus_if.start = 1'b1;
        bus_if.a     = 8'hC3;
        bus_if.b     = 8'h5A;
        bus_if.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_eq("mrst_busy", 32'(bus_if.busy), 32'd0);
        expect_eq("mrst_sum",  32'(bus_if.sum),  32'd0);
        expect_eq("mrst_cout", 32'(bus_if.cout), 32'd0);
        expect_eq("mrst_ovf",  32'(bus_if.ovf),  32'd0);
        check_idle_fa("mrst");
        for (int k = 0; k < W + 2; k++) begin
            expect_eq("mrst_nodone", 32'(bus_if.done), 32'd0);
            @(negedge clk);
        end
        run_op(8'h12, 8'h34, 1'b0, "after_rst");

        for (int n = 0; n < 200; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
